ramio_bist: RTL and testbench

//  Memory self-test master sitting directly upstream of RAMIO and driving its CPU-side request port.
//  On start it writes a generated 32-bit pattern to word_count consecutive words from base_addr, then

---
 rtl/ramio_bist.sv | 187 ++++++++++++++++++
 tb/tb_ramio_bist.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ramio_bist.sv
// Memory self-test master: writes seed + i*PATTERN_STEP to word_count words from base_addr via RAMIO, then reads back and compares.
// All outputs are registered, so enable drops for exactly one cycle between transactions; each wait is bounded by TIMEOUT_CYCLES.
module ramio_bist #(
  parameter int          COUNT_BITWIDTH = 16,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] PATTERN_STEP   = 32'h9E37_79B9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [31:0]               base_addr,
  input  logic [COUNT_BITWIDTH-1:0] word_count,
  input  logic [31:0]               seed,
  output logic                      running,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout,
  output logic [COUNT_BITWIDTH-1:0] error_count,
  output logic [31:0]               first_fail_addr,
  output logic                      enable,
  output logic [1:0]                write_type,
  output logic [2:0]                read_type,
  output logic [31:0]               address,
  output logic [31:0]               data_in,
  input  logic [31:0]               data_out,
  input  logic                      data_out_ready,
  input  logic                      busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, DONE} state_t;

  state_t                    state;
  logic [31:0]               base_q;
  logic [31:0]               seed_q;
  logic [COUNT_BITWIDTH-1:0] count_q;
  logic [COUNT_BITWIDTH-1:0] idx;
  logic [31:0]               pat;
  logic [31:0]               cur_addr;
  logic [TW-1:0]             wait_cnt;

  logic last_word;
  logic mismatch;
  logic wait_expired;

  assign last_word    = (idx == count_q - 1'b1);
  assign mismatch     = (data_out != pat);
  assign wait_expired = (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      base_q          <= '0;
      seed_q          <= '0;
      count_q         <= '0;
      idx             <= '0;
      pat             <= '0;
      cur_addr        <= '0;
      wait_cnt        <= '0;
      running         <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      timeout         <= 1'b0;
      error_count     <= '0;
      first_fail_addr <= '0;
      enable          <= 1'b0;
      write_type      <= 2'b00;
      read_type       <= 3'b000;
      address         <= '0;
      data_in         <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            base_q          <= {base_addr[31:2], 2'b00};
            cur_addr        <= {base_addr[31:2], 2'b00};
            seed_q          <= seed;
            pat             <= seed;
            count_q         <= word_count;
            idx             <= '0;
            timeout         <= 1'b0;
            error_count     <= '0;
            first_fail_addr <= '0;
            if (word_count == '0) begin
              state   <= DONE;
              done    <= 1'b1;
              pass    <= 1'b1;
            end else begin
              state   <= WR_ISSUE;
              done    <= 1'b0;
              pass    <= 1'b0;
              running <= 1'b1;
            end
          end
        end

        WR_ISSUE: begin
          enable     <= 1'b1;
          write_type <= 2'b11;
          address    <= cur_addr;
          data_in    <= pat;
          wait_cnt   <= '0;
          state      <= WR_WAIT;
        end

        WR_WAIT: begin
          if (!busy) begin
            enable     <= 1'b0;
            write_type <= 2'b00;
            address    <= '0;
            data_in    <= '0;
            if (last_word) begin
              idx      <= '0;
              cur_addr <= base_q;
              pat      <= seed_q;
              state    <= RD_ISSUE;
            end else begin
              idx      <= idx + 1'b1;
              cur_addr <= cur_addr + 32'd4;
              pat      <= pat + PATTERN_STEP;
              state    <= WR_ISSUE;
            end
          end else if (wait_expired) begin
            enable     <= 1'b0;
            write_type <= 2'b00;
            address    <= '0;
            data_in    <= '0;
            running    <= 1'b0;
            done       <= 1'b1;
            pass       <= 1'b0;
            timeout    <= 1'b1;
            state      <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RD_ISSUE: begin
          enable    <= 1'b1;
          read_type <= 3'b111;
          address   <= cur_addr;
          wait_cnt  <= '0;
          state     <= RD_WAIT;
        end

        RD_WAIT: begin
          if (data_out_ready) begin
            enable    <= 1'b0;
            read_type <= 3'b000;
            address   <= '0;
            if (mismatch) begin
              if (!(&error_count)) error_count <= error_count + 1'b1;
              // error_count never returns to zero, so this captures only the first miss
              if (error_count == '0) first_fail_addr <= address;
            end
            if (last_word) begin
              running <= 1'b0;
              done    <= 1'b1;
              pass    <= !mismatch && (error_count == '0);
              state   <= DONE;
            end else begin
              idx      <= idx + 1'b1;
              cur_addr <= cur_addr + 32'd4;
              pat      <= pat + PATTERN_STEP;
              state    <= RD_ISSUE;
            end
          end else if (wait_expired) begin
            enable    <= 1'b0;
            read_type <= 3'b000;
            address   <= '0;
            running   <= 1'b0;
            done      <= 1'b1;
            pass      <= 1'b0;
            timeout   <= 1'b1;
            state     <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ramio_bist.sv
// Bench for ramio_bist: behavioural RAMIO model with configurable latency, read corruption and stuck busy.
// Writes are checked against a queue of expected (address, data); final status against a vector table.
module tb_ramio_bist;

  localparam int          CB   = 16;
  localparam int          TMO  = 1024;
  localparam logic [31:0] STEP = 32'h9E37_79B9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   base_addr = '0;
  logic [CB-1:0] word_count = '0;
  logic [31:0]   seed = '0;
  logic          running, done, pass, timeout;
  logic [CB-1:0] error_count;
  logic [31:0]   first_fail_addr;
  logic          enable;
  logic [1:0]    write_type;
  logic [2:0]    read_type;
  logic [31:0]   address, data_in, data_out;
  logic          data_out_ready, busy;

  ramio_bist #(.COUNT_BITWIDTH(CB), .TIMEOUT_CYCLES(TMO), .PATTERN_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .seed(seed), .running(running), .done(done), .pass(pass), .timeout(timeout),
    .error_count(error_count), .first_fail_addr(first_fail_addr), .enable(enable),
    .write_type(write_type), .read_type(read_type), .address(address), .data_in(data_in),
    .data_out(data_out), .data_out_ready(data_out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // RAMIO model: a request completes once enable has been held for lat cycles.
  logic [31:0] mem [256];
  int          lat = 1;
  int          lat_cnt = 0;
  logic        stuck_busy = 1'b0;
  logic        corrupt_en = 1'b0;
  logic        corrupt_all = 1'b0;
  logic [31:0] corrupt_addr = '0;
  logic        corrupt_hit;

  assign busy           = stuck_busy || (enable && lat_cnt < lat);
  assign data_out_ready = !stuck_busy && enable && read_type == 3'b111 && lat_cnt >= lat;
  assign corrupt_hit    = corrupt_all || (corrupt_en && address == corrupt_addr);
  assign data_out       = mem[address[9:2]] ^ (corrupt_hit ? 32'h0000_0100 : 32'h0);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t  exp_q[$];
  int   gap = 0;
  logic prev_en = 1'b0;
  logic en_seen = 1'b0;

  always @(negedge clk) begin
    lat_cnt = enable ? lat_cnt + 1 : 0;
    if (enable) en_seen = 1'b1;
    if (!rst && enable && write_type == 2'b11 && !(stuck_busy || lat_cnt < lat)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected write", address, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write addr", address, e.addr);
        chk("write data", data_in, e.data);
      end
      mem[address[9:2]] = data_in;
    end
    if (enable && !prev_en) chk("enable gap", gap, 1);
    if (!running || enable) gap = 0;
    else gap++;
    prev_en = enable;
  end

  task automatic push_writes(input logic [31:0] b, input int cnt, input logic [31:0] s);
    logic [31:0] a, p;
    a = {b[31:2], 2'b00};
    p = s;
    for (int i = 0; i < cnt; i++) begin
      exp_q.push_back('{addr: a, data: p});
      a = a + 32'd4;
      p = p + STEP;
    end
  endtask

  task automatic pulse_start(input logic [31:0] b, input int cnt, input logic [31:0] s);
    @(negedge clk);
    base_addr  = b;
    word_count = CB'(cnt);
    seed       = s;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit, output int cyc);
    cyc = 0;
    while (!done && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) chk({name, " done within bound"}, 32'd0, 32'd1);
  endtask

  task automatic chk_ramio_idle(input string name);
    chk({name, " enable"}, {31'd0, enable}, 32'd0);
    chk({name, " types"}, {27'd0, write_type, read_type}, 32'd0);
    chk({name, " address"}, address, 32'd0);
    chk({name, " data_in"}, data_in, 32'd0);
  endtask

  typedef struct {
    logic [31:0] base;
    int          cnt;
    logic [31:0] seed;
    int          lat;
    logic        c_en;
    logic        c_all;
    logic [31:0] c_addr;
    logic        exp_pass;
    int          exp_err;
    logic [31:0] exp_ffa;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cyc;
    vecs[0] = '{32'd16,         4,  32'd0,         1, 1'b0, 1'b0, 32'd0,     1'b1, 0, 32'd0};
    vecs[1] = '{32'd16,         4,  32'd0,         2, 1'b1, 1'b0, 32'd24,    1'b0, 1, 32'd24};
    vecs[2] = '{32'd0,          32, 32'h1234_5678, 3, 1'b0, 1'b0, 32'd0,     1'b1, 0, 32'd0};
    vecs[3] = '{32'h0000_0103,  3,  32'hFFFF_FFFF, 1, 1'b1, 1'b0, 32'h104,   1'b0, 1, 32'h104};
    vecs[4] = '{32'hFFFF_FFF8,  4,  32'hA5A5_0000, 2, 1'b1, 1'b0, 32'h4,     1'b0, 1, 32'h4};
    vecs[5] = '{32'h0000_0040,  5,  32'h0000_0001, 4, 1'b0, 1'b1, 32'd0,     1'b0, 5, 32'h40};

    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset status", {28'd0, running, done, pass, timeout}, 32'd0);
    chk("reset error_count", {16'd0, error_count}, 32'd0);
    chk("reset first_fail_addr", first_fail_addr, 32'd0);
    chk_ramio_idle("reset");
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      lat          = vecs[v].lat;
      corrupt_en   = vecs[v].c_en;
      corrupt_all  = vecs[v].c_all;
      corrupt_addr = vecs[v].c_addr;
      push_writes(vecs[v].base, vecs[v].cnt, vecs[v].seed);
      pulse_start(vecs[v].base, vecs[v].cnt, vecs[v].seed);
      chk($sformatf("v%0d running", v), {31'd0, running}, 32'd1);
      wait_done($sformatf("v%0d", v), 5000, cyc);
      chk($sformatf("v%0d pass", v), {31'd0, pass}, {31'd0, vecs[v].exp_pass});
      chk($sformatf("v%0d timeout", v), {31'd0, timeout}, 32'd0);
      chk($sformatf("v%0d error_count", v), {16'd0, error_count}, 32'(vecs[v].exp_err));
      chk($sformatf("v%0d first_fail_addr", v), first_fail_addr, vecs[v].exp_ffa);
      chk($sformatf("v%0d writes left", v), exp_q.size(), 32'd0);
      chk_ramio_idle($sformatf("v%0d done", v));
      if (v == 0) begin
        chk("word@16", mem[4], 32'h0000_0000);
        chk("word@20", mem[5], 32'h9E37_79B9);
        chk("word@24", mem[6], 32'h3C6E_F372);
        chk("word@28", mem[7], 32'hDAA6_6D2B);
      end
    end
    corrupt_en  = 1'b0;
    corrupt_all = 1'b0;

    // count == 0 finishes one cycle after start without touching RAMIO
    en_seen = 1'b0;
    pulse_start(32'h200, 0, 32'h55);
    chk("zero-count done", {30'd0, done, pass}, 32'd3);
    chk("zero-count running", {31'd0, running}, 32'd0);
    repeat (4) @(negedge clk);
    chk("zero-count no enable", {31'd0, en_seen}, 32'd0);

    // start pulsed mid-run must not disturb the test in progress
    lat = 2;
    push_writes(32'd0, 32, 32'hCAFE_0000);
    pulse_start(32'd0, 32, 32'hCAFE_0000);
    repeat (20) @(negedge clk);
    base_addr = 32'h300; word_count = 2; seed = 32'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("midstart", 5000, cyc);
    chk("midstart pass", {31'd0, pass}, 32'd1);
    chk("midstart error_count", {16'd0, error_count}, 32'd0);
    chk("midstart writes left", exp_q.size(), 32'd0);

    // reset during RD_WAIT abandons the request, then a restart passes
    push_writes(32'h80, 4, 32'h7);
    pulse_start(32'h80, 4, 32'h7);
    cyc = 0;
    while (!(enable && read_type == 3'b111) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached read phase", {31'd0, enable && read_type == 3'b111}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset status", {28'd0, running, done, pass, timeout}, 32'd0);
    chk("midreset error_count", {16'd0, error_count}, 32'd0);
    chk_ramio_idle("midreset");
    rst = 1'b0;
    exp_q.delete();
    push_writes(32'h80, 4, 32'h7);
    pulse_start(32'h80, 4, 32'h7);
    wait_done("restart", 5000, cyc);
    chk("restart pass", {31'd0, pass}, 32'd1);

    // busy stuck high: the first write times out
    stuck_busy = 1'b1;
    pulse_start(32'h100, 2, 32'h0);
    wait_done("stuck", TMO + 200, cyc);
    chk("stuck timeout", {31'd0, timeout}, 32'd1);
    chk("stuck pass", {31'd0, pass}, 32'd0);
    chk("stuck running", {31'd0, running}, 32'd0);
    chk("stuck wait bound", {31'd0, cyc >= TMO && cyc <= TMO + 2}, 32'd1);
    chk_ramio_idle("stuck");
    stuck_busy = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
